// File: rtl/tdc_tx_scheduler_if.sv
// Handshake bundle between the TDC/UART environment and the transmit scheduler.
// master = environment (drives measurements and UART busy), slave = scheduler.
interface tdc_tx_scheduler_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [39:0]   meas_in;
    logic          meas_valid;
    logic          uart_busy;
    logic [39:0]   uart_data;
    logic          uart_start;
    logic [LW-1:0] fifo_level;
    logic [15:0]   drop_count;
    logic          ack_error;

    modport master (
        output meas_in, meas_valid, uart_busy,
        input  uart_data, uart_start, fifo_level, drop_count, ack_error
    );

    modport slave (
        input  meas_in, meas_valid, uart_busy,
        output uart_data, uart_start, fifo_level, drop_count, ack_error
    );
endinterface

// File: rtl/tdc_tx_scheduler.sv
// Shares one UART transmitter between buffered TDC measurements and periodic
// heartbeat status records {FF, drop_count, seq}; status has strict priority.
module tdc_tx_scheduler #(
    parameter int DEPTH       = 8,
    parameter int HB_PERIOD   = 200000000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk_200m,
    input  logic              rst_n,
    tdc_tx_scheduler_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int HBW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
    localparam int TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [39:0] CLAMP_WORD = 40'hFE_FFFF_FFFF;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

    state_t        state_reg, state_next;
    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg, level_next;
    logic [39:0]   uart_data_reg;
    logic [15:0]   drop_reg, drop_next;
    logic [15:0]   seq_reg;
    logic          status_pending_reg;
    logic          ack_error_reg;
    logic [TW-1:0] tmo_reg;

    logic          hb_wrap;
    logic          fifo_full, fifo_empty;
    logic          push, drop, do_pop, sel_status, ack_timeout;
    logic [39:0]   meas_sat;

    // Byte FF in the top position is reserved to mark status records.
    assign meas_sat   = (bus.meas_in[39:32] == 8'hFF) ? CLAMP_WORD : bus.meas_in;
    assign fifo_full  = (level_reg == LW'(DEPTH));
    assign fifo_empty = (level_reg == '0);
    assign push       = bus.meas_valid && (!fifo_full || do_pop);
    assign drop       = bus.meas_valid && fifo_full && !do_pop;

    generate
        if (HB_PERIOD > 0) begin : g_hb
            logic [HBW-1:0] hb_reg;

            always_ff @(posedge clk_200m or negedge rst_n) begin
                if (!rst_n) begin
                    hb_reg <= '0;
                end else if (hb_reg == HBW'(HB_PERIOD - 1)) begin
                    hb_reg <= '0;
                end else begin
                    hb_reg <= hb_reg + 1'b1;
                end
            end

            assign hb_wrap = (hb_reg == HBW'(HB_PERIOD - 1));
        end else begin : g_no_hb
            assign hb_wrap = 1'b0;
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        sel_status  = 1'b0;
        do_pop      = 1'b0;
        ack_timeout = 1'b0;
        case (state_reg)
            IDLE: begin
                if (status_pending_reg) begin
                    sel_status = 1'b1;
                    state_next = LAUNCH;
                end else if (!fifo_empty) begin
                    do_pop     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.uart_busy) begin
                    state_next = WAIT_DONE;
                end else if (tmo_reg == TW'(ACK_TIMEOUT - 1)) begin
                    ack_timeout = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A drop in the same cycle as a status launch is the first drop of the new window.
    always_comb begin
        drop_next = drop_reg;
        if (sel_status) begin
            drop_next = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_reg != 16'hFFFF)) begin
            drop_next = drop_reg + 16'd1;
        end
    end

    assign level_next = level_reg + LW'(push) - LW'(do_pop);

    always_ff @(posedge clk_200m) begin
        if (push) begin
            mem[wr_ptr_reg] <= meas_sat;
        end
    end

    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            level_reg          <= '0;
            uart_data_reg      <= '0;
            drop_reg           <= '0;
            seq_reg            <= '0;
            status_pending_reg <= 1'b0;
            ack_error_reg      <= 1'b0;
            tmo_reg            <= '0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            drop_reg  <= drop_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (sel_status) begin
                uart_data_reg <= {8'hFF, drop_reg, seq_reg};
                seq_reg       <= seq_reg + 16'd1;
            end else if (do_pop) begin
                uart_data_reg <= mem[rd_ptr_reg];
            end
            // Clearing wins over a wrap: a wrap while pending is already set is ignored.
            if (sel_status) begin
                status_pending_reg <= 1'b0;
            end else if (hb_wrap) begin
                status_pending_reg <= 1'b1;
            end
            if (ack_timeout) begin
                ack_error_reg <= 1'b1;
            end
            tmo_reg <= (state_reg == WAIT_ACK) ? tmo_reg + 1'b1 : '0;
        end
    end

    assign bus.uart_data  = uart_data_reg;
    assign bus.uart_start = (state_reg == LAUNCH);
    assign bus.fifo_level = level_reg;
    assign bus.drop_count = drop_reg;
    assign bus.ack_error  = ack_error_reg;

endmodule

// File: tb/tb_tdc_tx_scheduler.sv
// Bench for tdc_tx_scheduler: vector table, hand sequences for the multi-cycle
// corners, and a random run scored by a queue-based transmit model.
`timescale 1ns/1ps
module tb_tdc_tx_scheduler;
    localparam int DEPTH = 8;
    localparam int HB    = 100;
    localparam int ACKT  = 16;

    logic clk_200m;
    logic rst_n;

    tdc_tx_scheduler_if #(.DEPTH(DEPTH)) bus ();

    tdc_tx_scheduler #(
        .DEPTH(DEPTH),
        .HB_PERIOD(HB),
        .ACK_TIMEOUT(ACKT)
    ) dut (
        .clk_200m(clk_200m),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk_200m = 1'b0;
    always #2.5 clk_200m = ~clk_200m;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] clamp_ref(input logic [39:0] x);
        return (x[39:32] == 8'hFF) ? 40'hFE_FFFF_FFFF : x;
    endfunction

    // UART stand-in: auto mode raises busy the cycle after uart_start for frame_len cycles.
    int   busy_mode   = 0;
    logic forced_busy = 1'b0;
    int   frame_len   = 4;
    int   busy_left   = 0;

    always @(posedge clk_200m) begin
        #1;
        if (!rst_n) begin
            busy_left     = 0;
            bus.uart_busy = 1'b0;
        end else if (busy_mode == 1) begin
            bus.uart_busy = forced_busy;
        end else begin
            bus.uart_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (bus.uart_start) busy_left = frame_len;
        end
    end

    // Reference model: a launch reveals a decision one edge earlier; status if one
    // was owed, otherwise the oldest stored measurement. Pushes see the post-pop space.
    logic [39:0] mq[$];
    logic [15:0] m_drop = 16'd0;
    logic [15:0] m_seq  = 16'd0;
    bit          m_pend = 1'b0;
    bit          m_was_pend;
    int          m_edges = 0;
    bit          m_inrst = 1'b1;
    logic        p_valid = 1'b0;
    logic [39:0] p_in    = '0;
    logic [39:0] m_exp;

    always @(negedge clk_200m) begin
        if (!rst_n) begin
            mq.delete();
            m_drop  = 16'd0;
            m_seq   = 16'd0;
            m_pend  = 1'b0;
            m_edges = 0;
            m_inrst = 1'b1;
        end else begin
            if (!m_inrst) begin
                m_was_pend = m_pend;
                m_edges++;
                if (bus.uart_start) begin
                    if (m_pend) begin
                        m_exp  = {8'hFF, m_drop, m_seq};
                        m_drop = 16'd0;
                        m_seq  = m_seq + 16'd1;
                        m_pend = 1'b0;
                        check("mon_word", bus.uart_data, m_exp);
                    end else if (mq.size() > 0) begin
                        m_exp = mq.pop_front();
                        check("mon_word", bus.uart_data, m_exp);
                    end else begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL mon_launch: got launch of 0x%0h, expected no launch", bus.uart_data);
                    end
                end
                if (p_valid) begin
                    if (mq.size() < DEPTH) mq.push_back(clamp_ref(p_in));
                    else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
                if ((m_edges % HB) == 0 && !m_was_pend) m_pend = 1'b1;
            end
            check("mon_level", 64'(bus.fifo_level), 64'(mq.size()));
            check("mon_drop", bus.drop_count, m_drop);
            m_inrst = 1'b0;
            p_valid = bus.meas_valid;
            p_in    = bus.meas_in;
        end
    end

    task automatic tick();
        @(posedge clk_200m);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.meas_valid = 1'b0;
        busy_mode      = 0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [39:0] din;
        logic [39:0] dout;
    } vec_t;

    vec_t        vecs[6];
    logic [39:0] exp4[4];
    logic [39:0] lw[$];
    int          lc[$];
    int          got;
    bit          seen;

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.meas_in    = '0;
        bus.meas_valid = 1'b0;
        bus.uart_busy  = 1'b0;
        rst_n          = 1'b0;
        repeat (2) tick();
        check("rst_data", bus.uart_data, 40'd0);
        check("rst_start", bus.uart_start, 1'b0);
        check("rst_level", 64'(bus.fifo_level), 64'd0);
        check("rst_drop", bus.drop_count, 16'd0);
        check("rst_ackerr", bus.ack_error, 1'b0);

        // Single-measurement latency and clamp table.
        vecs[0] = '{40'h00_0000_1234, 40'h00_0000_1234};
        vecs[1] = '{40'hFF_0000_0001, 40'hFE_FFFF_FFFF};
        vecs[2] = '{40'hFE_FFFF_FFFF, 40'hFE_FFFF_FFFF};
        vecs[3] = '{40'hFF_FFFF_FFFF, 40'hFE_FFFF_FFFF};
        vecs[4] = '{40'h7F_8000_00FF, 40'h7F_8000_00FF};
        vecs[5] = '{40'h00_0000_0000, 40'h00_0000_0000};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            frame_len = 4;
            tick();
            bus.meas_in    = vecs[i].din;
            bus.meas_valid = 1'b1;
            tick();
            bus.meas_valid = 1'b0;
            check($sformatf("v%0d_level_n1", i), 64'(bus.fifo_level), 64'd1);
            check($sformatf("v%0d_start_n1", i), bus.uart_start, 1'b0);
            tick();
            check($sformatf("v%0d_start_n2", i), bus.uart_start, 1'b1);
            check($sformatf("v%0d_data", i), bus.uart_data, vecs[i].dout);
            check($sformatf("v%0d_level_n2", i), 64'(bus.fifo_level), 64'd0);
            repeat (8) tick();
            check($sformatf("v%0d_data_hold", i), bus.uart_data, vecs[i].dout);
            check($sformatf("v%0d_ackerr", i), bus.ack_error, 1'b0);
        end

        // Overflow with busy held high: v0 launched, v1..v8 stored, v9 dropped.
        do_reset();
        busy_mode   = 1;
        forced_busy = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.meas_in    = 40'h01_0000_0000 + 40'(i);
            bus.meas_valid = 1'b1;
            tick();
        end
        bus.meas_valid = 1'b0;
        check("ovf_level", 64'(bus.fifo_level), 64'd8);
        check("ovf_drop", bus.drop_count, 16'd1);
        check("ovf_launched", bus.uart_data, 40'h01_0000_0000);
        repeat (5) tick();
        busy_left = 0;
        busy_mode = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (bus.uart_start && bus.uart_data[39:32] == 8'hFF) begin
                seen = 1'b1;
                check("ovf_status", bus.uart_data, {8'hFF, 16'h0001, 16'h0000});
                tick();
                check("ovf_drop_clr", bus.drop_count, 16'd0);
            end else begin
                tick();
            end
        end
        check("ovf_status_seen", seen, 1'b1);

        // Heartbeat alone: status words 100 cycles apart with incrementing seq.
        do_reset();
        lc.delete();
        lw.delete();
        for (int c = 0; c < 260; c++) begin
            if (bus.uart_start) begin
                lc.push_back(c);
                lw.push_back(bus.uart_data);
            end
            tick();
        end
        check("hb_count", 64'(lc.size()), 64'd2);
        if (lc.size() >= 2) begin
            check("hb_first_cycle", 64'(lc[0]), 64'd101);
            check("hb_spacing", 64'(lc[1] - lc[0]), 64'd100);
            check("hb_word0", lw[0], {8'hFF, 16'h0000, 16'h0000});
            check("hb_word1", lw[1], {8'hFF, 16'h0000, 16'h0001});
        end

        // Priority: status pending and three queued words meet in the same IDLE cycle.
        do_reset();
        busy_mode   = 1;
        forced_busy = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.meas_in    = 40'h22_0000_0000 + 40'(i);
            bus.meas_valid = 1'b1;
            tick();
        end
        bus.meas_valid = 1'b0;
        repeat (105) tick();
        exp4[0] = {8'hFF, 16'h0000, 16'h0000};
        exp4[1] = 40'h22_0000_0001;
        exp4[2] = 40'h22_0000_0002;
        exp4[3] = 40'h22_0000_0003;
        busy_left = 0;
        busy_mode = 0;
        got = 0;
        for (int i = 0; i < 200 && got < 4; i++) begin
            if (bus.uart_start) begin
                check($sformatf("prio_word%0d", got), bus.uart_data, exp4[got]);
                got++;
            end
            tick();
        end
        check("prio_count", 64'(got), 64'd4);

        // Ack timeout, next launch, then asynchronous reset in WAIT_DONE.
        do_reset();
        busy_mode   = 1;
        forced_busy = 1'b0;
        frame_len   = 10;
        tick();
        bus.meas_in    = 40'h33_0000_00A0;
        bus.meas_valid = 1'b1;
        tick();
        bus.meas_in    = 40'h33_0000_00A1;
        tick();
        bus.meas_valid = 1'b0;
        check("tmo_launch", bus.uart_start, 1'b1);
        repeat (ACKT) tick();
        check("tmo_err_before", bus.ack_error, 1'b0);
        tick();
        check("tmo_err_set", bus.ack_error, 1'b1);
        busy_left = 0;
        busy_mode = 0;
        tick();
        check("tmo_next_start", bus.uart_start, 1'b1);
        check("tmo_next_data", bus.uart_data, 40'h33_0000_00A1);
        bus.meas_in    = 40'h33_0000_00A2;
        bus.meas_valid = 1'b1;
        tick();
        tick();
        bus.meas_valid = 1'b0;
        check("tmo_err_sticky", bus.ack_error, 1'b1);
        tick();
        check("rst2_level_pre", 64'(bus.fifo_level), 64'd2);
        rst_n = 1'b0;
        #1;
        check("rst2_data", bus.uart_data, 40'd0);
        check("rst2_start", bus.uart_start, 1'b0);
        check("rst2_level", 64'(bus.fifo_level), 64'd0);
        check("rst2_drop", bus.drop_count, 16'd0);
        check("rst2_ackerr", bus.ack_error, 1'b0);

        // Random traffic scored by the model; frequent overflow and heartbeats.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            frame_len      = int'($urandom_range(1, 10));
            bus.meas_valid = ($urandom_range(0, 99) < 25);
            bus.meas_in    = {($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom), 32'($urandom)};
            tick();
        end
        bus.meas_valid = 1'b0;
        repeat (300) tick();
        check("rnd_drained", 64'(bus.fifo_level), 64'd0);
        check("rnd_ackerr", bus.ack_error, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
